// File: rtl/asrv32_clint.sv
// asrv32_clint: core-local interruptor that answers the asrv32 data-memory port.
// It decodes loads and stores inside a 64 KiB window and holds shadow copies of
// msip, mtime and mtimecmp. Timer writes are forwarded to the core as full
// 64-bit load pulses.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge); asynchronous active-low reset
//   i_addr                data address from the core
//   i_wr_data, i_wr_mask  store data (byte-lane aligned) and byte enables
//   i_wr_en               store strobe
//   i_ext_irq_async       raw external interrupt line
//   o_hit                 combinational: i_addr lies inside the window
//   o_rd_data             registered read data, one cycle after i_addr
//   o_software_interrupt  msip bit 0
//   o_external_interrupt  i_ext_irq_async after a two-flop synchroniser
//   o_mtime_wr/din        one-cycle pulse and 64-bit value loaded into the core's mtime
//   o_mtimecmp_wr/din     one-cycle pulse and 64-bit value loaded into the core's mtimecmp
module asrv32_clint #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          CLK_FREQ_MHZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_mask,
  input  logic        i_wr_en,
  input  logic        i_ext_irq_async,
  output logic        o_hit,
  output logic [31:0] o_rd_data,
  output logic        o_software_interrupt,
  output logic        o_external_interrupt,
  output logic        o_mtime_wr,
  output logic [63:0] o_mtime_din,
  output logic        o_mtimecmp_wr,
  output logic [63:0] o_mtimecmp_din
);

  localparam int PRE_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_MHZ - 1);

  typedef enum logic [1:0] {ST_INIT, ST_SYNC, ST_RUN} state_t;

  state_t             state;
  logic               msip;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic [PRE_W-1:0]   prescaler;
  logic               ext_sync_p0;
  logic               ext_sync_p1;

  logic [13:0]        word_sel;
  logic               sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic               wr_ok;
  logic               msip_wr, cmp_wr, time_wr, tick;
  logic [63:0]        mtimecmp_nxt;
  logic [63:0]        mtime_nxt;
  logic [31:0]        rd_mux;
  logic               unused_addr_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign o_hit            = (i_addr[31:16] == BASE_ADDR[31:16]);
  assign word_sel         = i_addr[15:2];
  assign unused_addr_bits = ^i_addr[1:0];

  assign sel_msip    = (word_sel == 14'h0000);
  assign sel_cmp_lo  = (word_sel == 14'h1000);
  assign sel_cmp_hi  = (word_sel == 14'h1001);
  assign sel_time_lo = (word_sel == 14'h2FFE);
  assign sel_time_hi = (word_sel == 14'h2FFF);

  // Stores are ignored until the boot-time timer loads have been issued.
  assign wr_ok   = i_wr_en & o_hit & (|i_wr_mask) & (state == ST_RUN);
  assign msip_wr = wr_ok & sel_msip & i_wr_mask[0];
  assign cmp_wr  = wr_ok & (sel_cmp_lo | sel_cmp_hi);
  assign time_wr = wr_ok & (sel_time_lo | sel_time_hi);
  assign tick    = (prescaler == PRE_LAST);

  // Merged 64-bit values: the written half from the bus, the other half from the shadow.
  always_comb begin
    mtimecmp_nxt = mtimecmp;
    mtime_nxt    = mtime;
    if (sel_cmp_lo)  mtimecmp_nxt[31:0]  = byte_merge(mtimecmp[31:0],  i_wr_data, i_wr_mask);
    if (sel_cmp_hi)  mtimecmp_nxt[63:32] = byte_merge(mtimecmp[63:32], i_wr_data, i_wr_mask);
    if (sel_time_lo) mtime_nxt[31:0]     = byte_merge(mtime[31:0],     i_wr_data, i_wr_mask);
    if (sel_time_hi) mtime_nxt[63:32]    = byte_merge(mtime[63:32],    i_wr_data, i_wr_mask);
  end

  always_comb begin
    rd_mux = 32'h0;
    if (o_hit) begin
      if (sel_msip)    rd_mux = {31'h0, msip};
      if (sel_cmp_lo)  rd_mux = mtimecmp[31:0];
      if (sel_cmp_hi)  rd_mux = mtimecmp[63:32];
      if (sel_time_lo) rd_mux = mtime[31:0];
      if (sel_time_hi) rd_mux = mtime[63:32];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_INIT;
      msip           <= 1'b0;
      mtime          <= 64'h0;
      mtimecmp       <= '1;
      prescaler      <= '0;
      ext_sync_p0    <= 1'b0;
      ext_sync_p1    <= 1'b0;
      o_rd_data      <= 32'h0;
      o_mtime_wr     <= 1'b0;
      o_mtime_din    <= 64'h0;
      o_mtimecmp_wr  <= 1'b0;
      o_mtimecmp_din <= 64'h0;
    end else begin
      // sync stage boundary: _p0 -> _p1
      ext_sync_p0   <= i_ext_irq_async;
      ext_sync_p1   <= ext_sync_p0;
      o_rd_data     <= rd_mux;
      o_mtime_wr    <= 1'b0;
      o_mtimecmp_wr <= 1'b0;
      case (state)
        ST_INIT: begin
          o_mtimecmp_wr  <= 1'b1;
          o_mtimecmp_din <= '1;
          state          <= ST_SYNC;
        end
        ST_SYNC: begin
          o_mtime_wr  <= 1'b1;
          o_mtime_din <= 64'h0;
          state       <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          if (msip_wr) msip <= i_wr_data[0];
          if (cmp_wr) begin
            mtimecmp       <= mtimecmp_nxt;
            o_mtimecmp_din <= mtimecmp_nxt;
            o_mtimecmp_wr  <= 1'b1;
          end
          // A software write to mtime overrides the tick and restarts the microsecond count.
          if (time_wr) begin
            mtime       <= mtime_nxt;
            o_mtime_din <= mtime_nxt;
            o_mtime_wr  <= 1'b1;
            prescaler   <= '0;
          end else if (tick) begin
            mtime     <= mtime + 64'd1;
            prescaler <= '0;
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end
      endcase
    end
  end

  assign o_software_interrupt = msip;
  assign o_external_interrupt = ext_sync_p1;

endmodule
